// File: rtl/sweep_pkg.sv
// Shared definitions for the triangle-wave counter sequencer:
// state encoding and default datapath widths.
package sweep_pkg;

    localparam int N_DEF      = 4;
    localparam int PASS_W_DEF = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_UP   = 2'd1;
    localparam logic [1:0] ST_DOWN = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        UP   = ST_UP,
        DOWN = ST_DOWN
    } state_t;

endpackage

// File: rtl/updown_counter.sv
// Plain N-bit up/down counter register with synchronous load.
// Load wins over enable; it carries no knowledge of the sweep window.
module updown_counter
    import sweep_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         load,
    input  logic [N-1:0] load_val,
    input  logic         up_down,
    output logic [N-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en) begin
            cnt <= up_down ? cnt + 1'b1 : cnt - 1'b1;
        end
    end

endmodule

// File: rtl/counter_sweep_ctrl.sv
// Sweep sequencer: drives the counter lo -> hi -> lo for a programmed
// number of passes, then pulses done. All outputs come straight from flops.
module counter_sweep_ctrl
    import sweep_pkg::*;
#(
    parameter int N      = N_DEF,
    parameter int PASS_W = PASS_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [N-1:0]      lo,
    input  logic [N-1:0]      hi,
    input  logic [PASS_W-1:0] passes,
    output logic [N-1:0]      cnt,
    output logic              up_down,
    output logic              busy,
    output logic [PASS_W-1:0] pass_cnt,
    output logic              done,
    output logic              err
);

    state_t              state_q, state_d;
    logic [N-1:0]        lo_q, hi_q;
    logic [PASS_W-1:0]   passes_q;
    logic [PASS_W-1:0]   pass_cnt_d, pass_inc;
    logic                busy_d, up_down_d, done_d, err_d, latch_win;
    logic                ctr_en, ctr_load, ctr_dir;
    logic [N-1:0]        ctr_val;

    // Handshake: start is a level sampled only in IDLE; done/err are
    // single-cycle pulses with no acknowledge; abort acts on the next edge.
    always_comb begin
        state_d    = state_q;
        busy_d     = busy;
        up_down_d  = up_down;
        done_d     = 1'b0;
        err_d      = 1'b0;
        latch_win  = 1'b0;
        ctr_en     = 1'b0;
        ctr_load   = 1'b0;
        ctr_val    = cnt;
        ctr_dir    = up_down;
        pass_inc   = pass_cnt + 1'b1;
        pass_cnt_d = pass_cnt;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if ((lo >= hi) || (passes == '0)) begin
                        err_d = 1'b1;
                    end else begin
                        latch_win  = 1'b1;
                        ctr_load   = 1'b1;
                        ctr_val    = lo;
                        pass_cnt_d = '0;
                        busy_d     = 1'b1;
                        up_down_d  = 1'b1;
                        state_d    = UP;
                    end
                end
            end
            UP: begin
                if (abort) begin
                    busy_d    = 1'b0;
                    up_down_d = 1'b1;
                    state_d   = IDLE;
                end else if (cnt != hi_q) begin
                    ctr_en  = 1'b1;
                    ctr_dir = 1'b1;
                end else begin
                    // Turn: hi has already been shown, so jump straight to hi-1.
                    ctr_load  = 1'b1;
                    ctr_val   = hi_q - 1'b1;
                    up_down_d = 1'b0;
                    state_d   = DOWN;
                end
            end
            DOWN: begin
                if (abort) begin
                    busy_d    = 1'b0;
                    up_down_d = 1'b1;
                    state_d   = IDLE;
                end else if (cnt != lo_q) begin
                    ctr_en  = 1'b1;
                    ctr_dir = 1'b0;
                end else begin
                    pass_cnt_d = pass_inc;
                    up_down_d  = 1'b1;
                    if (pass_inc == passes_q) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ctr_load = 1'b1;
                        ctr_val  = lo_q + 1'b1;
                        state_d  = UP;
                    end
                end
            end
            default: begin
                busy_d    = 1'b0;
                up_down_d = 1'b1;
                state_d   = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            busy     <= 1'b0;
            up_down  <= 1'b1;
            done     <= 1'b0;
            err      <= 1'b0;
            pass_cnt <= '0;
            lo_q     <= '0;
            hi_q     <= '0;
            passes_q <= '0;
        end else begin
            state_q  <= state_d;
            busy     <= busy_d;
            up_down  <= up_down_d;
            done     <= done_d;
            err      <= err_d;
            pass_cnt <= pass_cnt_d;
            if (latch_win) begin
                lo_q     <= lo;
                hi_q     <= hi;
                passes_q <= passes;
            end
        end
    end

    updown_counter #(.N(N)) u_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (ctr_en),
        .load     (ctr_load),
        .load_val (ctr_val),
        .up_down  (ctr_dir),
        .cnt      (cnt)
    );

endmodule

// File: tb/tb_counter_sweep_ctrl.sv
// Self-checking bench for counter_sweep_ctrl: table of sweep commands with a
// triangle-wave reference queue, plus hand sequences for abort/reset/back-to-back.
module tb_counter_sweep_ctrl;
    import sweep_pkg::*;

    localparam int N  = 4;
    localparam int PW = 4;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          abort;
    logic [N-1:0]  lo;
    logic [N-1:0]  hi;
    logic [PW-1:0] passes;
    logic [N-1:0]  cnt;
    logic          up_down;
    logic          busy;
    logic [PW-1:0] pass_cnt;
    logic          done;
    logic          err;

    typedef struct {
        logic [N-1:0]  lo;
        logic [N-1:0]  hi;
        logic [PW-1:0] passes;
        logic          exp_err;
    } vec_t;

    vec_t            vecs[7];
    logic [PW+N:0]   exp_q[$];   // {pass_cnt, up_down, cnt}
    int              n_tests;
    int              n_fail;
    logic [N-1:0]    last_lo;
    logic [PW-1:0]   last_passes;

    counter_sweep_ctrl #(.N(N), .PASS_W(PW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .abort    (abort),
        .lo       (lo),
        .hi       (hi),
        .passes   (passes),
        .cnt      (cnt),
        .up_down  (up_down),
        .busy     (busy),
        .pass_cnt (pass_cnt),
        .done     (done),
        .err      (err)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver / checker tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic push_sweep(input logic [N-1:0] l, input logic [N-1:0] h, input logic [PW-1:0] p);
        logic [N-1:0]  v;
        logic [PW-1:0] pi;
        exp_q.push_back({{PW{1'b0}}, 1'b1, l});
        for (int k = 0; k < int'(p); k++) begin
            pi = PW'(k);
            for (int x = int'(l) + 1; x <= int'(h); x++) begin
                v = N'(x);
                exp_q.push_back({pi, 1'b1, v});
            end
            for (int x = int'(h) - 1; x >= int'(l); x--) begin
                v = N'(x);
                exp_q.push_back({pi, 1'b0, v});
            end
        end
    endtask

    task automatic run_vec(input vec_t v);
        logic [PW+N:0] e;
        lo     = v.lo;
        hi     = v.hi;
        passes = v.passes;
        start  = 1'b1;
        if (!v.exp_err) push_sweep(v.lo, v.hi, v.passes);
        tick();
        start = 1'b0;
        if (v.exp_err) begin
            check("err_pulse", 32'(err), 32'd1);
            check("err_busy", 32'(busy), 32'd0);
            check("err_cnt_hold", 32'(cnt), 32'(last_lo));
            check("err_pass_hold", 32'(pass_cnt), 32'(last_passes));
            tick();
            check("err_one_cycle", 32'(err), 32'd0);
        end else begin
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("sweep_busy", 32'(busy), 32'd1);
                check("sweep_cnt", 32'(cnt), 32'(e[N-1:0]));
                check("sweep_up_down", 32'(up_down), 32'(e[N]));
                check("sweep_pass_cnt", 32'(pass_cnt), 32'(e[PW+N:N+1]));
                check("sweep_no_done", 32'(done), 32'd0);
                check("sweep_no_err", 32'(err), 32'd0);
                tick();
            end
            check("end_busy", 32'(busy), 32'd0);
            check("end_done", 32'(done), 32'd1);
            check("end_cnt", 32'(cnt), 32'(v.lo));
            check("end_pass_cnt", 32'(pass_cnt), 32'(v.passes));
            check("end_up_down", 32'(up_down), 32'd1);
            tick();
            check("done_one_cycle", 32'(done), 32'd0);
            check("end_cnt_hold", 32'(cnt), 32'(v.lo));
            last_lo     = v.lo;
            last_passes = v.passes;
        end
    endtask

    task automatic start_sweep(input int l, input int h, input int p);
        lo     = N'(l);
        hi     = N'(h);
        passes = PW'(p);
        start  = 1'b1;
        tick();
        start  = 1'b0;
    endtask

    task automatic wait_cnt(input logic [N-1:0] val, input logic dir, input string name);
        int k;
        k = 0;
        while (!(busy && cnt == val && up_down == dir) && k < 64) begin
            tick();
            k++;
        end
        check(name, 32'(busy && cnt == val && up_down == dir), 32'd1);
    endtask

    task automatic wait_done(input string name);
        int k;
        k = 0;
        while (!done && k < 100) begin
            tick();
            k++;
        end
        check(name, 32'(done), 32'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_tests     = 0;
        n_fail      = 0;
        last_lo     = '0;
        last_passes = '0;
        rst_n  = 1'b0;
        start  = 1'b0;
        abort  = 1'b0;
        lo     = '0;
        hi     = '0;
        passes = '0;

        vecs[0] = '{lo: 4'd2,  hi: 4'd4,  passes: 4'd1, exp_err: 1'b0};
        vecs[1] = '{lo: 4'd5,  hi: 4'd5,  passes: 4'd3, exp_err: 1'b1};
        vecs[2] = '{lo: 4'd0,  hi: 4'd15, passes: 4'd2, exp_err: 1'b0};
        vecs[3] = '{lo: 4'd7,  hi: 4'd3,  passes: 4'd1, exp_err: 1'b1};
        vecs[4] = '{lo: 4'd1,  hi: 4'd6,  passes: 4'd0, exp_err: 1'b1};
        vecs[5] = '{lo: 4'd3,  hi: 4'd9,  passes: 4'd3, exp_err: 1'b0};
        vecs[6] = '{lo: 4'd14, hi: 4'd15, passes: 4'd1, exp_err: 1'b0};

        tick();
        tick();
        check("rst_cnt", 32'(cnt), 32'd0);
        check("rst_up_down", 32'(up_down), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        tick();
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_pass_cnt", 32'(pass_cnt), 32'd0);
        check("idle_err", 32'(err), 32'd0);

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Abort in DOWN at cnt=4
        start_sweep(1, 6, 1);
        wait_cnt(4'd4, 1'b0, "reach_down_4");
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_down_busy", 32'(busy), 32'd0);
        check("abort_down_cnt", 32'(cnt), 32'd4);
        check("abort_down_done", 32'(done), 32'd0);
        check("abort_down_dir", 32'(up_down), 32'd1);
        check("abort_down_pass", 32'(pass_cnt), 32'd0);
        tick();
        check("abort_down_no_done", 32'(done), 32'd0);
        check("abort_down_hold", 32'(cnt), 32'd4);

        // Abort on the turn cycle
        start_sweep(1, 6, 2);
        wait_cnt(4'd6, 1'b1, "reach_turn");
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_turn_busy", 32'(busy), 32'd0);
        check("abort_turn_cnt", 32'(cnt), 32'd6);
        check("abort_turn_dir", 32'(up_down), 32'd1);
        check("abort_turn_done", 32'(done), 32'd0);

        // Start while busy is ignored
        start_sweep(2, 5, 1);
        check("busy_start_cnt0", 32'(cnt), 32'd2);
        tick();
        lo     = 4'd9;
        hi     = 4'd1;
        passes = 4'd0;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        check("busy_start_err", 32'(err), 32'd0);
        check("busy_start_cnt", 32'(cnt), 32'd4);
        check("busy_start_busy", 32'(busy), 32'd1);
        tick();
        check("busy_start_err2", 32'(err), 32'd0);
        check("busy_start_cnt2", 32'(cnt), 32'd5);
        wait_done("busy_start_done");
        check("busy_start_end_cnt", 32'(cnt), 32'd2);
        tick();

        // start and abort together in IDLE: start wins
        abort = 1'b1;
        start_sweep(4, 6, 1);
        abort = 1'b0;
        check("idle_abort_busy", 32'(busy), 32'd1);
        check("idle_abort_cnt", 32'(cnt), 32'd4);
        check("idle_abort_err", 32'(err), 32'd0);
        wait_done("idle_abort_done");
        tick();

        // Back-to-back start in the done cycle
        start_sweep(2, 4, 1);
        wait_done("b2b_first_done");
        start_sweep(3, 5, 2);
        check("b2b_busy", 32'(busy), 32'd1);
        check("b2b_cnt", 32'(cnt), 32'd3);
        check("b2b_pass_cnt", 32'(pass_cnt), 32'd0);
        check("b2b_done", 32'(done), 32'd0);
        check("b2b_dir", 32'(up_down), 32'd1);
        wait_done("b2b_second_done");
        check("b2b_end_pass", 32'(pass_cnt), 32'd2);
        tick();

        // Asynchronous reset mid-sweep
        start_sweep(1, 6, 1);
        wait_cnt(4'd3, 1'b1, "reach_cnt_3");
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_cnt", 32'(cnt), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_dir", 32'(up_down), 32'd1);
        check("async_rst_pass", 32'(pass_cnt), 32'd0);
        check("async_rst_done", 32'(done), 32'd0);
        check("async_rst_err", 32'(err), 32'd0);
        #1 rst_n = 1'b1;
        tick();
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_cnt", 32'(cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/counter_sweep_ctrl.md
# counter_sweep_ctrl

Sequencer for the lab's N-bit up/down counter datapath. On a start command it loads a programmed window, drives the counter up from `lo` to `hi` and back down to `lo`, and repeats for a programmed number of passes. It then reports completion. Used as the stimulus and scan source for downstream lab blocks that need a triangle-wave count.

## Interface
Parameters:
- `N`, default 4: counter width.
- `PASS_W`, default 4: width of the pass-count fields.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: sweep request. Sampled only in IDLE.
- `abort`, input, 1: terminate the sweep in progress.
- `lo`, input, N: lower bound of the window (unsigned).
- `hi`, input, N: upper bound of the window (unsigned).
- `passes`, input, PASS_W: number of full up/down passes.
- `cnt`, output, N: counter value.
- `up_down`, output, 1: direction of the next step (1 = up, 0 = down).
- `busy`, output, 1: high while a sweep is active.
- `pass_cnt`, output, PASS_W: passes completed in the current or most recent sweep.
- `done`, output, 1: one-cycle pulse when a sweep completes normally.
- `err`, output, 1: one-cycle pulse when a start request is rejected.

## Operation
- Reset values: state IDLE, `cnt`=0, `up_down`=1, `busy`=0, `pass_cnt`=0, `done`=0, `err`=0.
- Reset is asynchronous and clears all state at any time, including mid-sweep.
- States: IDLE, UP, DOWN.
- IDLE with `start`=1:
  - If `lo >= hi` or `passes == 0`: pulse `err`, stay in IDLE, leave `cnt` and `pass_cnt` unchanged.
  - Otherwise: latch `lo`, `hi`, `passes` internally, set `cnt`=lo, `pass_cnt`=0, `busy`=1, `up_down`=1, and go to UP.
- Inputs `lo`, `hi` and `passes` are ignored after acceptance. Only the latched copies are used.
- UP:
  - If `cnt != hi_q`: `cnt`+1.
  - Else: go to DOWN with `cnt`=hi_q-1 and `up_down`=0.
- DOWN:
  - If `cnt != lo_q`: `cnt`-1.
  - Else, the pass is complete:
    - If `pass_cnt+1 == passes_q`: increment `pass_cnt`, go to IDLE, set `busy`=0, pulse `done`, set `up_down`=1, hold `cnt`=lo_q.
    - Otherwise: increment `pass_cnt`, go to UP with `cnt`=lo_q+1 and `up_down`=1.
- `abort` in UP or DOWN:
  - Go to IDLE next edge with `busy`=0 and `up_down`=1.
  - `cnt` and `pass_cnt` hold their values.
  - No `done` pulse.
  - `abort` takes priority over a turn or pass-complete event in the same cycle.
- `abort` in IDLE has no effect. If `start` and `abort` are both high in IDLE, `start` is processed normally.
- `start` while busy is ignored; no `err` pulse.
- Arithmetic is unsigned N-bit. Because `lo < hi` is guaranteed, `cnt` never wraps. `pass_cnt` cannot overflow because it stops at `passes_q`.

## Timing
- All outputs are registered.
- `start` accepted at edge 0 → `cnt`=lo visible after edge 0.
- Per pass: 2·(hi−lo) cycles.
- `busy` is high for 2·(hi−lo)·passes + 1 cycles after acceptance.
- `done` rises on the same edge that `busy` falls, and lasts exactly one cycle.
- `err` rises on the edge after the rejected `start` and lasts one cycle.
- A new `start` is accepted in the cycle `done` is high (the controller is already in IDLE).
- `abort` latency: one edge.

## Structure
- Package `sweep_pkg` holds:
  - the state encoding localparams (IDLE, UP, DOWN, 2-bit);
  - the default values for `N` and `PASS_W`.
- Sub-module `updown_counter` (parameter `N`) is the datapath register. Its ports:
  - `clk`, `rst_n`;
  - `en`, `load`, `load_val`;
  - `up_down`;
  - `cnt`.
- Sub-module behaviour:
  - `load` has priority over `en`.
  - Steps by ±1 only when `en`=1.
- The FSM in `counter_sweep_ctrl` computes `en`, `load`, `load_val` and `up_down` each cycle. All sequencing lives in the FSM; the counter has no window logic.

## Test plan
- **Reset:** assert `rst_n`=0 mid-sweep at `cnt`=3 → all outputs return to their reset values immediately, without waiting for `clk`.
- **Single pass:** `lo`=2, `hi`=4, `passes`=1, `start` → `cnt` = 2,3,4,3,2. `busy` is high for 5 cycles. `done` pulses once. `pass_cnt`=1. `cnt` holds at 2.
- **Multi-pass:** `lo`=0, `hi`=15 (N=4), `passes`=2 → `cnt` = 0..15..0..15..0 with no wrap. `busy` is high for 61 cycles. `pass_cnt` = 1 then 2.
- **Rejects:** `start` with `lo`=5, `hi`=5 → `err` pulses, `busy` stays 0. `start` with `passes`=0 → `err` pulses. `start` while busy → ignored, no `err`.
- **Abort:**
  - With `lo`=1, `hi`=6, assert `abort` while in DOWN at `cnt`=4 → IDLE after one edge, `cnt`=4, no `done`.
  - `abort` on the exact turn cycle (`cnt`=hi in UP) → IDLE, `cnt`=hi.
- **Back-to-back:** assert `start` in the `done` cycle with new `lo`=3, `hi`=5 → accepted. `cnt`=3 on the next cycle. `pass_cnt` clears to 0.
